// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the load FIFO entry layout and a one-hot destination helper
// for the writeback arbiter.
package writeback_arbiter_pkg;
   localparam int REG_ADDR_W   = 5;
   localparam int DATA_W       = 32;
   localparam int STARVE_CNT_W = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // 37-bit load FIFO entry: {dest[4:0], data[31:0]}
   typedef struct packed {
      reg_addr_t dest;
      data_t     data;
   } ld_entry_t;

   function automatic logic [31:0] dest_onehot(input reg_addr_t dest);
      dest_onehot = 32'd1 << dest;
   endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// ALU / load / register-file bundle of the writeback arbiter. WB_STALL_COUNT_EN
// adds the stall counter pair (StallCount, StallCountClr).
interface writeback_arbiter_if;
   import writeback_arbiter_pkg::*;

   logic      AluValid;
   reg_addr_t AluDest;
   data_t     AluData;
   logic      AluStall;
   logic      LdValid;
   logic      LdReady;
   reg_addr_t LdDest;
   data_t     LdData;
   logic [31:0] PendingMask;
   data_t     WriteData;
   reg_addr_t WriteRegister;
   logic      RegWrite;
`ifdef WB_STALL_COUNT_EN
   logic [31:0] StallCount;
   logic      StallCountClr;
`endif

   modport master (
`ifdef WB_STALL_COUNT_EN
      output StallCountClr,
      input  StallCount,
`endif
      output AluValid, AluDest, AluData, LdValid, LdDest, LdData,
      input  AluStall, LdReady, PendingMask, WriteData, WriteRegister, RegWrite
   );

   modport slave (
`ifdef WB_STALL_COUNT_EN
      input  StallCountClr,
      output StallCount,
`endif
      input  AluValid, AluDest, AluData, LdValid, LdDest, LdData,
      output AluStall, LdReady, PendingMask, WriteData, WriteRegister, RegWrite
   );
endinterface

// File: rtl/writeback_arbiter_load_fifo.sv
// Load-result FIFO (LD_DEPTH entries, power of two); entry visible the cycle after
// push, no pop-through when full. Per-entry valid/dest are exposed for the pending mask.
module writeback_arbiter_load_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         push,
   input  ld_entry_t                    push_entry,
   input  logic                         pop,
   output logic                         full,
   output logic                         empty,
   output ld_entry_t                    head,
   output logic [LD_DEPTH-1:0]          entry_valid,
   output reg_addr_t [LD_DEPTH-1:0]     entry_dest
);
   localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

   ld_entry_t           mem [LD_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LD_DEPTH-1:0] valid;
   logic                do_push;
   logic                do_pop;

   assign full    = &valid;
   assign empty   = ~|valid;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Payload needs no reset: the valid bits alone decide what is live.
   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end
         if (do_push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
      end
   end

   always_comb begin
      entry_valid = valid;
      for (int i = 0; i < LD_DEPTH; i++) begin
         entry_dest[i] = mem[i].dest;
      end
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback: ALU has priority, buffered loads are forced through after
// STARVE_LIMIT lost cycles; writes to $0 are dropped. WB_STALL_COUNT_EN adds StallCount.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int LD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                Clk,
   input  logic                Reset_n,
   writeback_arbiter_if.slave  bus
);
   localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

   logic                     full;
   logic                     empty;
   ld_entry_t                head;
   logic [LD_DEPTH-1:0]      entry_valid;
   reg_addr_t [LD_DEPTH-1:0] entry_dest;

   logic [STARVE_CNT_W-1:0]  starve_cnt;
   logic                     force_ld;
   logic                     alu_wr;
   logic                     ld_pop;
   logic                     ld_push;
   logic                     ld_ready;
   logic                     alu_stall;
   logic                     wr_en;
   ld_entry_t                wr_entry;
   logic [31:0]              pending;

   logic                     reg_write_q;
   reg_addr_t                write_reg_q;
   data_t                    write_data_q;

   writeback_arbiter_load_fifo #(
      .LD_DEPTH (LD_DEPTH)
   ) u_load_fifo (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .push        (ld_push),
      .push_entry  ('{dest: bus.LdDest, data: bus.LdData}),
      .pop         (ld_pop),
      .full        (full),
      .empty       (empty),
      .head        (head),
      .entry_valid (entry_valid),
      .entry_dest  (entry_dest)
   );

   // Reset_n gates ready so no handshake can complete while the FIFO is held clear.
   assign ld_ready  = Reset_n && !full;
   assign ld_push   = bus.LdValid && ld_ready && (bus.LdDest != REG_ZERO);
   assign force_ld  = (starve_cnt == STARVE_MAX) && !empty;
   assign alu_wr    = bus.AluValid && (bus.AluDest != REG_ZERO);
   assign ld_pop    = !empty && (force_ld || !alu_wr);
   assign alu_stall = force_ld && bus.AluValid;

   always_comb begin
      wr_en    = 1'b0;
      wr_entry = head;
      if (force_ld) begin
         wr_en = 1'b1;
      end else if (alu_wr) begin
         wr_en    = 1'b1;
         wr_entry = '{dest: bus.AluDest, data: bus.AluData};
      end else if (ld_pop) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= REG_ZERO;
         write_data_q <= '0;
      end else begin
         reg_write_q <= wr_en;
         if (wr_en) begin
            write_reg_q  <= wr_entry.dest;
            write_data_q <= wr_entry.data;
         end
      end
   end

   // Counts only cycles where the ALU beat a waiting load; capped by the forced pop.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         starve_cnt <= '0;
      end else if (ld_pop || empty) begin
         starve_cnt <= '0;
      end else if (alu_wr) begin
         starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         if (entry_valid[i]) begin
            pending = pending | dest_onehot(entry_dest[i]);
         end
      end
   end

`ifdef WB_STALL_COUNT_EN
   logic [31:0] stall_count;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stall_count <= '0;
      end else if (bus.StallCountClr) begin
         stall_count <= '0;
      end else if (alu_stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

   assign bus.StallCount = stall_count;
`endif

   assign bus.LdReady       = ld_ready;
   assign bus.AluStall      = alu_stall;
   assign bus.PendingMask   = pending;
   assign bus.RegWrite      = reg_write_q;
   assign bus.WriteRegister = write_reg_q;
   assign bus.WriteData     = write_data_q;
endmodule
